round_sequencer: RTL and testbench

- Per-round controller for the tug-of-war datapath: arms a pseudo-random start delay, lights the LEDs, and arbitrates the first press between the two players.
- Issues winrnd/right/tie pulses to the scorer and sequences the clear phase.
- Detects end-of-game from the scorer's position vector and requests sounds from the audio block.
- Sits between the synchronised pushbuttons and the scorer/LED mux, all on the divided clock.

---
 rtl/round_sequencer.sv | 154 +++++++++++++++
 tb/tb_round_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// Round controller for the tug-of-war game: random start delay, first-press
// arbitration, scorer handshake, clear phase and end-of-game detection.
module round_sequencer #(
    parameter int DELAY_W        = 24,
    parameter int DELAY_MIN      = 1000,
    parameter int DELAY_SCALE    = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CLR_CYCLES     = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pbl,
    input  logic       pbr,
    input  logic [6:0] score,
    output logic       leds_on,
    output logic       clr,
    output logic       winrnd,
    output logic       right,
    output logic       tie,
    output logic       false_start,
    output logic       game_over,
    output logic       winner_right,
    output logic [1:0] tone_req
);

    typedef enum logic [2:0] {IDLE, ARM, LIT, SCORE, SETTLE, CLEAR, OVER} state_t;

    localparam logic [DELAY_W-1:0] CNT_MAX    = '1;
    localparam logic [DELAY_W-1:0] CNT_ONE    = DELAY_W'(1);
    localparam logic [DELAY_W-1:0] TIMEOUT_LD = DELAY_W'(TIMEOUT_CYCLES);
    localparam logic [DELAY_W-1:0] CLR_LD     = DELAY_W'(CLR_CYCLES);
    localparam logic [6:0]         END_MASK   = 7'b1000001;

    state_t             state;
    logic [7:0]         lfsr;
    logic               pbl_q, pbr_q;
    logic [DELAY_W-1:0] cnt;
    logic               el, er, fb, score_end;
    logic [63:0]        arm_sum;
    logic [DELAY_W-1:0] arm_ld;

    assign el        = pbl & ~pbl_q;
    assign er        = pbr & ~pbr_q;
    assign fb        = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign score_end = |(score & END_MASK);
    // wide sum so a large LFSR*scale saturates instead of wrapping
    assign arm_sum   = 64'(DELAY_MIN) + 64'(lfsr) * 64'(DELAY_SCALE);
    assign arm_ld    = (arm_sum > 64'(CNT_MAX)) ? CNT_MAX : arm_sum[DELAY_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            lfsr         <= 8'hA5;
            pbl_q        <= 1'b0;
            pbr_q        <= 1'b0;
            cnt          <= '0;
            leds_on      <= 1'b0;
            clr          <= 1'b0;
            winrnd       <= 1'b0;
            right        <= 1'b0;
            tie          <= 1'b0;
            false_start  <= 1'b0;
            game_over    <= 1'b0;
            winner_right <= 1'b0;
            tone_req     <= 2'd0;
        end else begin
            lfsr        <= {lfsr[6:0], fb};
            pbl_q       <= pbl;
            pbr_q       <= pbr;
            winrnd      <= 1'b0;
            right       <= 1'b0;
            tie         <= 1'b0;
            false_start <= 1'b0;
            tone_req    <= 2'd0;
            case (state)
                IDLE: begin
                    if (!pbl && !pbr) begin
                        state <= ARM;
                        cnt   <= arm_ld;
                    end
                end
                // edges beat counter expiry, so a press on the last ARM cycle is a false start
                ARM: begin
                    if (el && er) begin
                        tie   <= 1'b1;
                        clr   <= 1'b1;
                        cnt   <= CLR_LD;
                        state <= CLEAR;
                    end else if (el || er) begin
                        winrnd      <= 1'b1;
                        false_start <= 1'b1;
                        right       <= el;
                        tone_req    <= 2'd2;
                        state       <= SCORE;
                    end else if (cnt <= CNT_ONE) begin
                        leds_on  <= 1'b1;
                        tone_req <= 2'd1;
                        cnt      <= TIMEOUT_LD;
                        state    <= LIT;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                LIT: begin
                    if (el && er) begin
                        tie     <= 1'b1;
                        leds_on <= 1'b0;
                        clr     <= 1'b1;
                        cnt     <= CLR_LD;
                        state   <= CLEAR;
                    end else if (el || er) begin
                        winrnd   <= 1'b1;
                        right    <= er;
                        tone_req <= 2'd2;
                        leds_on  <= 1'b0;
                        state    <= SCORE;
                    end else if (cnt <= CNT_ONE) begin
                        leds_on <= 1'b0;
                        clr     <= 1'b1;
                        cnt     <= CLR_LD;
                        state   <= CLEAR;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                SCORE: state <= SETTLE;
                SETTLE: begin
                    if (score_end) begin
                        game_over    <= 1'b1;
                        winner_right <= score[0];
                        tone_req     <= 2'd3;
                        state        <= OVER;
                    end else begin
                        clr   <= 1'b1;
                        cnt   <= CLR_LD;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (cnt <= CNT_ONE && !pbl && !pbr) begin
                        clr   <= 1'b0;
                        cnt   <= arm_ld;
                        state <= ARM;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                OVER:    ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: directed vector table, hand sequences for tie /
// timeout / reset, then random buttons and scores against a phase-age model.
module tb_round_sequencer;

    localparam int DMIN = 4;
    localparam int DSC  = 1;
    localparam int TO   = 20;
    localparam int CLRN = 3;

    logic       clk = 1'b0;
    logic       rst, pbl, pbr;
    logic [6:0] score;
    logic       leds_on, clr, winrnd, right, tie, false_start, game_over, winner_right;
    logic [1:0] tone_req;

    int nerr = 0;
    int nchk = 0;

    round_sequencer #(
        .DELAY_W(24), .DELAY_MIN(DMIN), .DELAY_SCALE(DSC),
        .TIMEOUT_CYCLES(TO), .CLR_CYCLES(CLRN)
    ) dut (
        .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .score(score),
        .leds_on(leds_on), .clr(clr), .winrnd(winrnd), .right(right), .tie(tie),
        .false_start(false_start), .game_over(game_over), .winner_right(winner_right),
        .tone_req(tone_req)
    );

    always #5 clk = ~clk;

    // {leds_on, clr, winrnd, right, tie, false_start, game_over, winner_right, tone_req}
    function automatic logic [9:0] get_out();
        return {leds_on, clr, winrnd, right, tie, false_start, game_over, winner_right, tone_req};
    endfunction

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_leds(input int maxc);
        int n = 0;
        while (!leds_on && n < maxc) begin
            tick();
            n++;
        end
        nchk++;
        if (!leds_on) begin
            nerr++;
            $display("FAIL wait_leds: leds_on=%b after %0d cycles, want 1", leds_on, n);
        end
    endtask

    // Reference model: phase plus cycles-spent-in-phase, levels derived from phase
    localparam int P_IDLE = 0, P_ARM = 1, P_LIT = 2, P_SCORE = 3, P_SETTLE = 4, P_CLEAR = 5, P_OVER = 6;
    int         m_ph, m_age;
    longint     m_dur;
    logic [7:0] m_lf;
    logic       m_ql, m_qr, m_win, m_right, m_tie, m_fs, m_wr;
    logic [1:0] m_tone;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    function automatic longint arm_dur(input logic [7:0] v);
        longint d = longint'(DMIN) + longint'(v) * longint'(DSC);
        return (d > 64'hFFFFFF) ? 64'hFFFFFF : d;
    endfunction

    function automatic void model_reset();
        m_ph = P_IDLE; m_age = 0; m_dur = 0; m_lf = 8'hA5;
        m_ql = 0; m_qr = 0; m_win = 0; m_right = 0; m_tie = 0; m_fs = 0; m_wr = 0; m_tone = 0;
    endfunction

    function automatic void model_step();
        logic el = pbl && !m_ql;
        logic er = pbr && !m_qr;
        int   nph = m_ph;
        m_win = 0; m_right = 0; m_tie = 0; m_fs = 0; m_tone = 0;
        case (m_ph)
            P_IDLE: if (!pbl && !pbr) begin nph = P_ARM; m_dur = arm_dur(m_lf); end
            P_ARM: begin
                if (el && er) begin m_tie = 1; nph = P_CLEAR; end
                else if (el || er) begin m_win = 1; m_fs = 1; m_right = el; m_tone = 2; nph = P_SCORE; end
                else if (m_age + 1 >= m_dur) begin m_tone = 1; nph = P_LIT; end
            end
            P_LIT: begin
                if (el && er) begin m_tie = 1; nph = P_CLEAR; end
                else if (el || er) begin m_win = 1; m_right = er; m_tone = 2; nph = P_SCORE; end
                else if (m_age + 1 >= TO) nph = P_CLEAR;
            end
            P_SCORE:  nph = P_SETTLE;
            P_SETTLE: begin
                if (score[0] || score[6]) begin nph = P_OVER; m_wr = score[0]; m_tone = 3; end
                else nph = P_CLEAR;
            end
            P_CLEAR: if (m_age + 1 >= CLRN && !pbl && !pbr) begin nph = P_ARM; m_dur = arm_dur(m_lf); end
            default: ;
        endcase
        m_age = (nph == m_ph) ? m_age + 1 : 0;
        m_ph  = nph;
        m_lf  = lfsr_next(m_lf);
        m_ql  = pbl;
        m_qr  = pbr;
    endfunction

    function automatic logic [9:0] model_out();
        return {m_ph == P_LIT, m_ph == P_CLEAR, m_win, m_right, m_tie, m_fs,
                m_ph == P_OVER, m_wr && (m_ph == P_OVER), m_tone};
    endfunction

    typedef struct packed {
        logic        pbl;
        logic        pbr;
        logic [6:0]  score;
        logic [15:0] cycles;
        logic [9:0]  exp;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // first round straight out of reset: ARM = 4 + 0xA5 = 169 cycles
        tbl[0]  = '{1'b0, 1'b0, 7'h00, 16'd169, 10'b0000000000}; // still ARM
        tbl[1]  = '{1'b0, 1'b0, 7'h00, 16'd1,   10'b1000000001}; // LIT entry, tone 1
        tbl[2]  = '{1'b0, 1'b0, 7'h00, 16'd1,   10'b1000000000};
        tbl[3]  = '{1'b1, 1'b0, 7'h00, 16'd1,   10'b0010000010}; // left wins, tone 2
        tbl[4]  = '{1'b1, 1'b0, 7'h00, 16'd1,   10'b0000000000}; // SETTLE
        tbl[5]  = '{1'b0, 1'b0, 7'h00, 16'd1,   10'b0100000000}; // CLEAR
        tbl[6]  = '{1'b1, 1'b0, 7'h00, 16'd3,   10'b0100000000}; // held button extends CLEAR
        tbl[7]  = '{1'b0, 1'b0, 7'h00, 16'd1,   10'b0000000000}; // back to ARM
        tbl[8]  = '{1'b0, 1'b1, 7'h00, 16'd1,   10'b0010010010}; // false start, left wins
        tbl[9]  = '{1'b0, 1'b0, 7'h01, 16'd1,   10'b0000000000}; // SETTLE
        tbl[10] = '{1'b0, 1'b0, 7'h01, 16'd1,   10'b0000001111}; // OVER, right wins, tone 3
        tbl[11] = '{1'b1, 1'b0, 7'h01, 16'd1,   10'b0000001100};
        tbl[12] = '{1'b0, 1'b1, 7'h01, 16'd5,   10'b0000001100};

        rst = 1'b0; pbl = 1'b0; pbr = 1'b0; score = 7'h00;
        repeat (3) tick();
        chk("reset", get_out(), 10'b0);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            pbl = tbl[i].pbl; pbr = tbl[i].pbr; score = tbl[i].score;
            repeat (int'(tbl[i].cycles)) tick();
            chk($sformatf("vec%0d", i), get_out(), tbl[i].exp);
        end

        // reset while in OVER clears everything immediately
        pbl = 1'b0; pbr = 1'b0; score = 7'h00;
        rst = 1'b0;
        #1;
        chk("rst_async", get_out(), 10'b0);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_arm", get_out(), 10'b0);

        // simultaneous press while lit
        wait_leds(400);
        pbl = 1'b1; pbr = 1'b1;
        tick();
        chk("tie_pulse", get_out(), 10'b0100100000);
        tick();
        chk("tie_clear", get_out(), 10'b0100000000);
        pbl = 1'b0; pbr = 1'b0;

        // timeout, then held button stretches clr
        wait_leds(400);
        repeat (TO - 1) tick();
        chk("lit_last", get_out(), 10'b1000000000);
        tick();
        chk("timeout", get_out(), 10'b0100000000);
        pbl = 1'b1;
        repeat (10) tick();
        chk("clr_held", get_out(), 10'b0100000000);
        pbl = 1'b0;
        tick();
        chk("clr_release", get_out(), 10'b0000000000);

        // random buttons and scores against the model
        rst = 1'b0;
        tick();
        model_reset();
        chk("rand_reset", get_out(), model_out());
        for (int c = 0; c < 8000; c++) begin
            if (!rst) rst = 1'b1;
            else if ((m_ph == P_OVER && m_age > 30) || $urandom_range(0, 1999) == 0) rst = 1'b0;
            if ($urandom_range(0, 29) == 0) pbl = ~pbl;
            if ($urandom_range(0, 29) == 0) pbr = ~pbr;
            if ($urandom_range(0, 79) == 0) begin
                pbl = 1'($urandom_range(0, 1));
                pbr = pbl;
            end
            if ($urandom_range(0, 5) == 0) score = $urandom_range(0, 1) ? 7'h01 : 7'h40;
            else score = 7'(1) << $urandom_range(1, 5);
            if (!rst) model_reset();
            @(posedge clk);
            if (rst) model_step();
            #1;
            chk($sformatf("rand%0d", c), get_out(), model_out());
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
